// File: rtl/exec_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_mem_pkg
// Description : Shared types for the execute -> memory pipeline register.
//               Payload layout, its width, and the buffer occupancy states.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_mem_pkg;

    // Everything the memory stage needs from one executed instruction
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_p1;
        logic [3:0]  rd;
        logic        regWrite;
        logic        memWrite;
        logic [1:0]  resultSrc;
    } em_payload_t;

    localparam int EM_PAYLOAD_W = 104;

    // Encoding is {skid_valid, main_valid} so each bit is a direct valid flag
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } em_state_t;

endpackage : exec_mem_pkg
`default_nettype wire

// File: rtl/exec_mem_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : exec_mem_skid_reg
// Description : Two-entry elastic (skid) register between execute and memory.
//               Registered in_ready breaks the combinational ready path from
//               the memory stage; flush squashes both entries.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_mem_skid_reg
    import exec_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    // Execute side
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic [31:0] pc_p1_in,
    input  logic [3:0]  rd_in,
    input  logic        regWrite_in,
    input  logic        memWrite_in,
    input  logic [1:0]  resultSrc_in,
    // Memory side
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_result_out,
    output logic [31:0] write_data_out,
    output logic [31:0] pc_p1_out,
    output logic [3:0]  rd_out,
    output logic [1:0]  resultSrc_out,
    output logic        regWrite_out,
    output logic        memWrite_out
);

    em_state_t   r_state;
    logic        r_in_ready;
    em_payload_t r_main;
    em_payload_t r_skid;

    em_state_t   w_nxt_state;
    em_payload_t w_in_pl;
    logic [1:0]  w_state_bits;
    logic        w_main_vld;
    logic        w_skid_vld;
    logic        w_in_xfer;
    logic        w_out_xfer;

    // Valid flags are the raw state flop bits, so out_valid is a flop output
    assign w_state_bits = r_state;
    assign w_main_vld   = w_state_bits[0];
    assign w_skid_vld   = w_state_bits[1];

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = w_main_vld & out_ready;

    assign w_in_pl = '{
        alu_result: alu_result_in,
        write_data: write_data_in,
        pc_p1:      pc_p1_in,
        rd:         rd_in,
        regWrite:   regWrite_in,
        memWrite:   memWrite_in,
        resultSrc:  resultSrc_in
    };

    // Occupancy transition; flush overrides any transfer
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            EMPTY: if (w_in_xfer) w_nxt_state = ONE;
            ONE: begin
                if (w_in_xfer && !w_out_xfer)      w_nxt_state = TWO;
                else if (!w_in_xfer && w_out_xfer) w_nxt_state = EMPTY;
                else                               w_nxt_state = ONE;
            end
            TWO:     if (w_out_xfer) w_nxt_state = ONE;
            default: w_nxt_state = EMPTY;
        endcase
        if (flush) w_nxt_state = EMPTY;
    end

    // State and registered ready: ready drops only when both entries will be full
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_nxt_state;
            r_in_ready <= (w_nxt_state != TWO);
        end
    end

    // Payload movement; a word accepted during a flush is simply not captured
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (!flush) begin
            if (w_out_xfer && w_skid_vld) begin
                r_main <= r_skid;
            end else if (w_in_xfer && (!w_main_vld || w_out_xfer)) begin
                r_main <= w_in_pl;
            end else if (w_in_xfer) begin
                r_skid <= w_in_pl;
            end
        end
    end

    assign in_ready       = r_in_ready;
    assign out_valid      = w_main_vld;
    assign alu_result_out = r_main.alu_result;
    assign write_data_out = r_main.write_data;
    assign pc_p1_out      = r_main.pc_p1;
    assign rd_out         = r_main.rd;
    assign resultSrc_out  = r_main.resultSrc;
    // Stale or squashed head contents must never cause an architectural write
    assign regWrite_out   = r_main.regWrite & w_main_vld;
    assign memWrite_out   = r_main.memWrite & w_main_vld;

endmodule : exec_mem_skid_reg
`default_nettype wire

// File: tb/tb_exec_mem_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_mem_skid_reg
// Description : Scoreboard bench for the execute -> memory skid register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_mem_skid_reg;
    import exec_mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result_in;
    logic [31:0] write_data_in;
    logic [31:0] pc_p1_in;
    logic [3:0]  rd_in;
    logic        regWrite_in;
    logic        memWrite_in;
    logic [1:0]  resultSrc_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result_out;
    logic [31:0] write_data_out;
    logic [31:0] pc_p1_out;
    logic [3:0]  rd_out;
    logic [1:0]  resultSrc_out;
    logic        regWrite_out;
    logic        memWrite_out;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_out    = 0;
    em_payload_t exp_q[$];
    em_payload_t drv_pl;

    exec_mem_skid_reg dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result_in  (alu_result_in),
        .write_data_in  (write_data_in),
        .pc_p1_in       (pc_p1_in),
        .rd_in          (rd_in),
        .regWrite_in    (regWrite_in),
        .memWrite_in    (memWrite_in),
        .resultSrc_in   (resultSrc_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_result_out (alu_result_out),
        .write_data_out (write_data_out),
        .pc_p1_out      (pc_p1_out),
        .rd_out         (rd_out),
        .resultSrc_out  (resultSrc_out),
        .regWrite_out   (regWrite_out),
        .memWrite_out   (memWrite_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic em_payload_t mk(input logic [3:0] rd, input logic mw);
        em_payload_t p;
        p.alu_result = 32'h1000_0000 | {28'd0, rd};
        p.write_data = 32'hD000_0000 | {28'd0, rd};
        p.pc_p1      = 32'h0000_0100 + {28'd0, rd};
        p.rd         = rd;
        p.regWrite   = ~mw;
        p.memWrite   = mw;
        p.resultSrc  = rd[1:0];
        return p;
    endfunction

    task automatic set_in(input em_payload_t p, input logic v);
        drv_pl        = p;
        alu_result_in = p.alu_result;
        write_data_in = p.write_data;
        pc_p1_in      = p.pc_p1;
        rd_in         = p.rd;
        regWrite_in   = p.regWrite;
        memWrite_in   = p.memWrite;
        resultSrc_in  = p.resultSrc;
        in_valid      = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus side of the scoreboard: record every accepted, unsquashed word
    always @(negedge clk) begin
        if (reset && in_valid && in_ready && !flush) exp_q.push_back(drv_pl);
    end

    // Squashed words will never come out
    always @(posedge clk) begin
        if (reset && flush) exp_q.delete();
    end
    always @(negedge reset) exp_q.delete();

    // Monitor: every output transfer must match the oldest expected word
    always @(negedge clk) begin
        em_payload_t act;
        em_payload_t exp;
        if (reset && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got rd=%0d expected no output", rd_out);
            end else begin
                exp = exp_q.pop_front();
                act.alu_result = alu_result_out;
                act.write_data = write_data_out;
                act.pc_p1      = pc_p1_out;
                act.rd         = rd_out;
                act.regWrite   = regWrite_out;
                act.memWrite   = memWrite_out;
                act.resultSrc  = resultSrc_out;
                chk("out_payload", act, exp);
            end
        end
    end

    initial begin
        em_payload_t pa5;
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        pa5 = mk(4'd0, 1'b0);
        pa5.alu_result = 32'h0000_00A5;
        set_in(pa5, 1'b1);

        // Reset held with in_valid high
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu", alu_result_out, 0);
        chk("rst_wdata", write_data_out, 0);
        chk("rst_pc", pc_p1_out, 0);
        chk("rst_rd", rd_out, 0);
        chk("rst_rsrc", resultSrc_out, 0);
        chk("rst_regw", regWrite_out, 0);
        chk("rst_memw", memWrite_out, 0);

        // First accept after release
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("first_out_valid", out_valid, 1);
        chk("first_alu", alu_result_out, 32'h0000_00A5);
        set_in(pa5, 1'b0);
        step(); step();

        // Streaming 8 words with rd 1..8
        for (int i = 1; i <= 8; i++) begin
            set_in(mk(4'(i), 1'b0), 1'b1);
            @(negedge clk);
            chk("stream_in_ready", in_ready, 1);
            step();
        end
        set_in(mk(4'd0, 1'b0), 1'b0);
        step(); step();
        chk("stream_drained", out_valid, 0);

        // Backpressure: two pushes fill the buffer
        out_ready = 1'b0;
        set_in(mk(4'd3, 1'b0), 1'b1);
        step();
        chk("bp_ready_after_1", in_ready, 1);
        set_in(mk(4'd4, 1'b0), 1'b1);
        step();
        chk("bp_ready_after_2", in_ready, 0);
        set_in(mk(4'd0, 1'b0), 1'b0);
        step();
        chk("bp_hold_head", rd_out, 3);
        out_ready = 1'b1;
        step();
        chk("bp_ready_back", in_ready, 1);
        chk("bp_head_4", rd_out, 4);
        step(); step();

        // Flush while full of stores, with a new word offered
        out_ready = 1'b0;
        set_in(mk(4'd10, 1'b1), 1'b1);
        step();
        set_in(mk(4'd11, 1'b1), 1'b1);
        step();
        chk("fl_full", in_ready, 0);
        set_in(mk(4'd9, 1'b0), 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_in(mk(4'd0, 1'b0), 1'b0);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_memw", memWrite_out, 0);
        chk("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step(); step(); step();
        chk("fl_stays_empty", out_valid, 0);

        // Flush in ONE while an input is accepted: the input is discarded
        out_ready = 1'b0;
        set_in(mk(4'd12, 1'b0), 1'b1);
        step();
        set_in(mk(4'd13, 1'b0), 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_in(mk(4'd0, 1'b0), 1'b0);
        chk("fl1_out_valid", out_valid, 0);
        chk("fl1_regw", regWrite_out, 0);
        out_ready = 1'b1;
        step(); step();

        // Simultaneous in/out in ONE
        out_ready = 1'b0;
        set_in(mk(4'd5, 1'b0), 1'b1);
        step();
        chk("sim_head_5", rd_out, 5);
        set_in(mk(4'd6, 1'b0), 1'b1);
        out_ready = 1'b1;
        step();
        chk("sim_head_6", rd_out, 6);
        chk("sim_valid", out_valid, 1);
        chk("sim_ready", in_ready, 1);
        set_in(mk(4'd0, 1'b0), 1'b0);
        step(); step();

        // Asynchronous reset while full
        out_ready = 1'b0;
        set_in(mk(4'd7, 1'b1), 1'b1);
        step();
        set_in(mk(4'd8, 1'b1), 1'b1);
        step();
        chk("ar_full", in_ready, 0);
        set_in(mk(4'd0, 1'b0), 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_in_ready", in_ready, 1);
        chk("ar_alu", alu_result_out, 0);
        chk("ar_rd", rd_out, 0);
        chk("ar_memw", memWrite_out, 0);
        step();
        reset = 1'b1;
        step(); step();
        chk("ar_after_release", out_valid, 0);

        // Totals: A5, 8 streamed, 3/4, 5/6
        chk("total_outputs", n_out, 13);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_exec_mem_skid_reg
`default_nettype wire
